// File: rtl/cic_decim_sched.sv
// Sequencing controller for one CIC decimator: owns rate and enable, derives
// the CIC input/output strobes and a data-valid that masks the pipeline refill.
module cic_decim_sched #(
  parameter int         N            = 4,
  parameter int         MAX_RATE     = 128,
  parameter int         DEFAULT_RATE = 8,
  parameter int         FLUSH_OUTS   = N + 1,
  parameter logic [6:0] SR_ADDR      = 7'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        serial_strobe,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        sample_strobe,
  output logic        cic_enable,
  output logic [7:0]  cic_rate,
  output logic        cic_strobe_in,
  output logic        cic_strobe_out,
  output logic        data_valid,
  output logic        running
);

  typedef enum logic [1:0] {IDLE, CLEAR, FLUSH, RUN} state_t;

  localparam logic [7:0] MAX_R      = 8'(MAX_RATE);
  localparam logic [7:0] DEF_R      = 8'(DEFAULT_RATE);
  localparam logic [7:0] FLUSH_LOAD = 8'(FLUSH_OUTS);

  state_t     state_q, state_d;
  logic [7:0] rate_q, phase_q, flush_q;
  logic       enable_q, strobeOut_q, dvPipe_q, dataValid_q, running_q;
  logic       cfgWrite, terminal, flushDone;
  logic [7:0] rateClamped;
  logic       unusedBits;

  assign cfgWrite   = serial_strobe && (serial_addr == SR_ADDR);
  assign unusedBits = ^serial_data[31:9];

  always_comb begin
    rateClamped = serial_data[7:0];
    if (serial_data[7:0] < 8'd2)
      rateClamped = 8'd2;
    else if (serial_data[7:0] > MAX_R)
      rateClamped = MAX_R;
  end

  // A settings write in the same cycle as a sample wins, so that sample is dropped.
  assign cic_strobe_in = sample_strobe && !cfgWrite &&
                         ((state_q == FLUSH) || (state_q == RUN));
  assign terminal  = cic_strobe_in && (phase_q == 8'd0);
  assign flushDone = (state_q == FLUSH) && strobeOut_q && (flush_q == 8'd1);

  always_comb begin
    state_d = state_q;
    if (cfgWrite) begin
      state_d = serial_data[8] ? CLEAR : IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        CLEAR:   state_d = FLUSH;
        FLUSH:   state_d = flushDone ? RUN : FLUSH;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rate_q      <= DEF_R;
      phase_q     <= 8'd0;
      flush_q     <= 8'd0;
      enable_q    <= 1'b0;
      strobeOut_q <= 1'b0;
      dvPipe_q    <= 1'b0;
      dataValid_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      enable_q    <= (state_d == FLUSH) || (state_d == RUN);
      running_q   <= (state_d == RUN);
      strobeOut_q <= terminal;

      if (cfgWrite)
        rate_q <= rateClamped;

      if (state_q == CLEAR)
        phase_q <= rate_q - 8'd1;
      else if (cic_strobe_in)
        phase_q <= terminal ? (rate_q - 8'd1) : (phase_q - 8'd1);

      if (state_q == CLEAR)
        flush_q <= FLUSH_LOAD;
      else if ((state_q == FLUSH) && strobeOut_q && (flush_q != 8'd0))
        flush_q <= flush_q - 8'd1;

      // Two-stage valid pipe tracks the CIC output latency; leaving RUN kills it.
      dvPipe_q    <= strobeOut_q && (state_q == RUN) && (state_d == RUN);
      dataValid_q <= dvPipe_q && (state_d == RUN);
    end
  end

  assign cic_enable     = enable_q;
  assign cic_rate       = rate_q;
  assign cic_strobe_out = strobeOut_q;
  assign data_valid     = dataValid_q;
  assign running        = running_q;

endmodule

// File: tb/tb_cic_decim_sched.sv
// Scoreboard bench for cic_decim_sched: expected strobe_out/data_valid cycles are
// queued by the stimulus and consumed by an independent monitor.
module tb_cic_decim_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        serial_strobe;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        sample_strobe;
  logic        cic_enable;
  logic [7:0]  cic_rate;
  logic        cic_strobe_in;
  logic        cic_strobe_out;
  logic        data_valid;
  logic        running;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int soQ[$];
  int dvQ[$];

  cic_decim_sched dut (
    .clock          (clock),
    .reset          (reset),
    .serial_strobe  (serial_strobe),
    .serial_addr    (serial_addr),
    .serial_data    (serial_data),
    .sample_strobe  (sample_strobe),
    .cic_enable     (cic_enable),
    .cic_rate       (cic_rate),
    .cic_strobe_in  (cic_strobe_in),
    .cic_strobe_out (cic_strobe_out),
    .data_valid     (data_valid),
    .running        (running)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Drives one cycle's inputs just after the active edge; cyc then names that cycle.
  task automatic applyStimulus(input logic ss, input logic wr, input logic [7:0] rate,
                               input logic run, input logic rst);
    @(posedge clock);
    #1;
    reset         = rst;
    serial_strobe = wr;
    serial_addr   = 7'd0;
    serial_data   = {23'd0, run, rate};
    sample_strobe = ss;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every output event must match the head of its expectation queue.
  initial begin
    int expC;
    forever begin
      @(negedge clock);
      if (cic_strobe_out === 1'b1) begin
        checks++;
        if (soQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL strobe_out_unexpected cycle=%0d got=1 expected=none", cyc);
        end else begin
          expC = soQ.pop_front();
          if (expC != cyc) begin
            failures++;
            $display("[TB] FAIL strobe_out_time got=%0d expected=%0d", cyc, expC);
          end
        end
      end
      if (data_valid === 1'b1) begin
        checks++;
        if (dvQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL data_valid_unexpected cycle=%0d got=1 expected=none", cyc);
        end else begin
          expC = dvQ.pop_front();
          if (expC != cyc) begin
            failures++;
            $display("[TB] FAIL data_valid_time got=%0d expected=%0d", cyc, expC);
          end
        end
      end
    end
  end

  initial begin
    int t, a, b, c0, d, e;
    reset = 1'b1;
    serial_strobe = 1'b0;
    serial_addr = 7'd0;
    serial_data = 32'd0;
    sample_strobe = 1'b0;
    repeat (3) applyStimulus(0, 0, 8'd0, 0, 1);

    // Reset state, with a sample offered while idle
    applyStimulus(1, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("rst_enable", cic_enable, 0);
    checkOutput("rst_rate", cic_rate, 8);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_strobe_in", cic_strobe_in, 0);
    checkOutput("rst_strobe_out", cic_strobe_out, 0);
    checkOutput("rst_data_valid", data_valid, 0);

    // Rate 4, back-to-back samples, then run=0 with a valid in flight
    applyStimulus(0, 1, 8'd4, 1, 0);
    t = cyc;
    for (int k = 0; k < 9; k++) soQ.push_back(t + 6 + 4 * k);
    for (int k = 5; k < 8; k++) dvQ.push_back(t + 8 + 4 * k);
    applyStimulus(0, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s1_enable_clear", cic_enable, 0);
    checkOutput("s1_rate", cic_rate, 4);
    applyStimulus(1, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s1_enable_flush", cic_enable, 1);
    for (int c = t + 3; c <= t + 38; c++) begin
      applyStimulus(1, 0, 8'd0, 0, 0);
      @(negedge clock);
      if (c == t + 22) checkOutput("s1_running_before", running, 0);
      if (c == t + 23) checkOutput("s1_running_after", running, 1);
    end
    applyStimulus(1, 1, 8'd4, 0, 0);
    @(negedge clock);
    checkOutput("s1_stop_strobe_in", cic_strobe_in, 0);
    applyStimulus(1, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s1_idle_enable", cic_enable, 0);
    checkOutput("s1_idle_running", running, 0);
    checkOutput("s1_idle_strobe_in", cic_strobe_in, 0);
    checkOutput("s1_idle_dv_cancel", data_valid, 0);
    repeat (4) applyStimulus(1, 0, 8'd0, 0, 0);

    // Rate 0 clamps to 2
    applyStimulus(0, 1, 8'd0, 1, 0);
    a = cyc;
    for (int k = 0; k < 6; k++) soQ.push_back(a + 4 + 2 * k);
    dvQ.push_back(a + 16);
    applyStimulus(0, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s2_rate_lo", cic_rate, 2);
    checkOutput("s2_enable_clear", cic_enable, 0);
    for (int c = a + 2; c <= a + 14; c++) applyStimulus(1, 0, 8'd0, 0, 0);
    repeat (4) applyStimulus(0, 0, 8'd0, 0, 0);

    // Rate 200 clamps to 128; samples every other cycle
    applyStimulus(0, 1, 8'd200, 1, 0);
    b = cyc;
    soQ.push_back(b + 257);
    soQ.push_back(b + 513);
    applyStimulus(0, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s2_rate_hi", cic_rate, 128);
    for (int c = b + 2; c <= b + 513; c++)
      applyStimulus(((c - b) % 2) == 0, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s2_still_flushing", running, 0);
    repeat (3) applyStimulus(0, 0, 8'd0, 0, 0);

    // Rate 8 into RUN, then rewrite to 16 together with a sample
    applyStimulus(0, 1, 8'd8, 1, 0);
    c0 = cyc;
    for (int k = 0; k < 6; k++) soQ.push_back(c0 + 10 + 8 * k);
    applyStimulus(0, 0, 8'd0, 0, 0);
    for (int c = c0 + 2; c <= c0 + 50; c++) applyStimulus(1, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s3_running_r8", running, 1);
    applyStimulus(1, 1, 8'd16, 1, 0);
    d = cyc;
    @(negedge clock);
    checkOutput("s3_write_blocks_sample", cic_strobe_in, 0);
    for (int k = 0; k < 6; k++) soQ.push_back(d + 18 + 16 * k);
    dvQ.push_back(d + 100);
    applyStimulus(1, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s3_enable_clear", cic_enable, 0);
    checkOutput("s3_rate", cic_rate, 16);
    checkOutput("s3_clear_strobe_in", cic_strobe_in, 0);
    checkOutput("s3_dv_cancel", data_valid, 0);
    applyStimulus(1, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s3_enable_flush", cic_enable, 1);
    for (int c = d + 3; c <= d + 100; c++) begin
      applyStimulus(1, 0, 8'd0, 0, 0);
      @(negedge clock);
      if (c == d + 82) checkOutput("s3_running_before", running, 0);
      if (c == d + 83) checkOutput("s3_running_after", running, 1);
    end
    repeat (3) applyStimulus(0, 0, 8'd0, 0, 0);

    // Reset while two flush outputs remain and a strobe_out is pending
    applyStimulus(0, 1, 8'd4, 1, 0);
    e = cyc;
    for (int k = 0; k < 3; k++) soQ.push_back(e + 6 + 4 * k);
    applyStimulus(0, 0, 8'd0, 0, 0);
    for (int c = e + 2; c <= e + 16; c++) applyStimulus(1, 0, 8'd0, 0, 0);
    applyStimulus(1, 0, 8'd0, 0, 1);
    @(negedge clock);
    checkOutput("s4_strobe_in_flush", cic_strobe_in, 1);
    applyStimulus(1, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s4_rst_enable", cic_enable, 0);
    checkOutput("s4_rst_rate", cic_rate, 8);
    checkOutput("s4_rst_running", running, 0);
    checkOutput("s4_rst_strobe_out", cic_strobe_out, 0);
    checkOutput("s4_rst_data_valid", data_valid, 0);
    checkOutput("s4_rst_strobe_in", cic_strobe_in, 0);
    for (int c = e + 19; c <= e + 30; c++) applyStimulus(1, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("s4_stays_idle", cic_enable, 0);

    repeat (2) applyStimulus(0, 0, 8'd0, 0, 0);
    @(negedge clock);
    checkOutput("strobe_out_missing", 8'(soQ.size()), 0);
    checkOutput("data_valid_missing", 8'(dvQ.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_decim_sched.md
# cic_decim_sched

Sequencing controller for one `cic_decim` instance in the receive chain. It owns the decimation rate and the CIC enable, and derives `strobe_in`/`strobe_out` from the upstream sample strobe. It also qualifies the CIC output with a data-valid pulse that suppresses samples while the differentiator pipeline refills. It is configured through the standard serial settings bus and sits between the front-end strobe source and the halfband/output stage.

## Interface
- `N`, 4: CIC order of the controlled instance.
- `MAX_RATE`, 128: largest legal decimation (2^log2_of_max_rate).
- `DEFAULT_RATE`, 8: rate loaded at reset.
- `FLUSH_OUTS`, N+1: CIC output strobes discarded after each (re)enable.
- `SR_ADDR`, 7'd0: settings address decoded by this block.

- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `serial_strobe`  in  1  settings write qualifier.
- `serial_addr`  in  7  settings address.
- `serial_data`  in  32  settings word: [7:0] rate, [8] run, others ignored.
- `sample_strobe`  in  1  upstream sample valid, one cycle wide.
- `cic_enable`  out  1  to CIC `enable`.
- `cic_rate`  out  8  to CIC `rate`.
- `cic_strobe_in`  out  1  to CIC `strobe_in`.
- `cic_strobe_out`  out  1  to CIC `strobe_out`.
- `data_valid`  out  1  qualifies CIC `signal_out` in the same cycle.
- `running`  out  1  high in RUN state.

## Operation
- States:
  - IDLE: `cic_enable=0`.
  - CLEAR: one cycle, `cic_enable=0`.
  - FLUSH: `cic_enable=1`, outputs suppressed.
  - RUN: `cic_enable=1`, outputs valid.
- Settings write (`serial_strobe` and `serial_addr==SR_ADDR`):
  - Latch the rate with clamping: values 0 and 1 become 2; values above MAX_RATE become MAX_RATE.
  - run=1 from any state: go to CLEAR. The CIC is cleared even when already running.
  - run=0: go to IDLE.
- CLEAR → FLUSH unconditionally. The phase counter loads rate−1 and the flush counter loads FLUSH_OUTS.
- `cic_strobe_in = sample_strobe & (state==FLUSH | state==RUN)`. This output is combinational.
- Phase counter (8 bit):
  - Decrements on each `cic_strobe_in`.
  - A `cic_strobe_in` with counter==0 reloads rate−1 and schedules `cic_strobe_out` for the next cycle.
- Flush counter:
  - Decrements on each `cic_strobe_out` in FLUSH.
  - The `cic_strobe_out` that takes it to 0 moves the state to RUN on the same edge.
- `data_valid` is asserted 2 cycles after each `cic_strobe_out` issued in RUN. This matches the CIC pipeline register plus its output register.
- In FLUSH, `data_valid` is held low.
- A pending `data_valid` in its delay pipe is cancelled when the state leaves RUN.
- Simultaneous settings write and `sample_strobe`: the write wins, and that sample is not forwarded, because the next state is CLEAR or IDLE.
- `cic_rate` changes only on a settings write. The CIC is always held in clear (CLEAR state) for the cycle after the change.

## Timing
- Reset values:
  - State IDLE.
  - `cic_enable=0`, `cic_rate=DEFAULT_RATE`.
  - `cic_strobe_in=0`, `cic_strobe_out=0`, `data_valid=0`, `running=0`.
  - Counters 0, delay pipe cleared.
- Reset asserted mid-operation: all of the above take effect on the next edge, and any pending strobe or valid is dropped.
- Write at cycle t (run=1):
  - t+1: CLEAR, `cic_enable=0`, new `cic_rate` visible.
  - t+2: FLUSH, `cic_enable=1`. The first qualifying `sample_strobe` is at t+2 or later.
- `cic_strobe_out` occurs exactly one cycle after every R-th `cic_strobe_in`, where R is the clamped rate. It is never asserted in the same cycle as the R-th `cic_strobe_in`.
- Back-to-back `sample_strobe` (every cycle) is legal:
  - R=2 gives `cic_strobe_out` every 2nd cycle.
  - `cic_strobe_out` may coincide with a non-terminal `cic_strobe_in`.
- Latency from the R-th input to `data_valid`: 3 cycles.
- `running` is a registered decode of state==RUN.

## Test plan
- Reset, then write rate=4, run=1, then `sample_strobe` every cycle:
  - `cic_enable` is low in the cycle after the write and high in the cycle after that.
  - `cic_strobe_out` fires every 4 cycles.
  - The first 5 `cic_strobe_out` pulses produce no `data_valid`; the 6th produces `data_valid` 2 cycles later.
  - `running` rises after the 5th `cic_strobe_out`.
- Write rate=0 and then rate=200 → `cic_rate` reads 2 and 128 respectively; strobe_out spacing is 2 and 128 input strobes.
- While in RUN at rate=8, write rate=16, run=1 in the same cycle as `sample_strobe`:
  - That sample is not forwarded and CLEAR lasts 1 cycle.
  - No `data_valid` follows from the pre-write pipeline.
  - The flush of 5 outputs restarts at rate 16.
- Write run=0 mid-RUN → next cycle IDLE, `cic_enable=0`, `sample_strobe` blocked, pending `data_valid` cancelled.
- Assert `reset` for 1 cycle while FLUSH is 2 outputs from completion → all outputs return to reset values on the next edge, `cic_rate=8`, and the block stays IDLE until a new run=1 write.
